// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision types and constants for the float datapath blocks.
package fp32_pkg;

    localparam int          FP_EXP_BIAS = 127;
    localparam logic [31:0] FP_NAN      = 32'h7FC0_0000;
    localparam logic [31:0] FP_INF_MAG  = 32'h7F80_0000;
    localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } div_state_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    function automatic logic [31:0] fp32_pack(input logic s, input logic [7:0] e, input logic [22:0] m);
        return {s, e, m};
    endfunction

endpackage

// File: rtl/divider_float_seq_if.sv
// Operand/result handshake bundle for the sequential float divider.
interface divider_float_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient
    );

endinterface

// File: rtl/fp32_classify.sv
// Combinational single-precision operand classifier (denormals count as zero).
module fp32_classify
    import fp32_pkg::*;
(
    input  logic [7:0]  exp_i,
    input  logic [22:0] man_i,
    output logic        is_zero_o,
    output logic        is_inf_o,
    output logic        is_nan_o
);

    // Decode the exponent/mantissa fields into the three special classes
    always_comb begin
        is_zero_o = (exp_i == 8'h00);
        is_inf_o  = (exp_i == FP_EXP_MAX) && (man_i == 23'h0);
        is_nan_o  = (exp_i == FP_EXP_MAX) && (man_i != 23'h0);
    end

endmodule

// File: rtl/divider_float_seq.sv
// Iterative restoring single-precision divider, one quotient bit per clock.
// Define ROUND_NEAREST_EN for round-to-nearest-even (one extra iteration); default truncates.
module divider_float_seq
    import fp32_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    divider_float_seq_if.slave bus
);

`ifdef ROUND_NEAREST_EN
    localparam int QW = 26;
`else
    localparam int QW = 25;
`endif
    localparam logic [4:0] LAST_ITER = 5'(QW - 1);

    div_state_t        state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    fp32_t             a_q, a_d, b_q, b_d;
    logic [24:0]       rem_q, rem_d;
    logic [QW-1:0]     quo_q, quo_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [31:0]       quotient_q, quotient_d;

    logic              a_zero_s, a_inf_s, a_nan_s, b_zero_s, b_inf_s, b_nan_s;
    logic              nan_res_s, inf_res_s, zero_res_s, special_s;
    logic              sign_s;
    logic [31:0]       special_res_s, norm_res_s;
    logic [25:0]       diff_s;
    logic signed [9:0] exp_base_s, exp_s, exp_fin_s;
    logic [22:0]       man_s, man_fin_s;

    fp32_classify u_cls_a (.exp_i(a_q.exp), .man_i(a_q.man),
                           .is_zero_o(a_zero_s), .is_inf_o(a_inf_s), .is_nan_o(a_nan_s));
    fp32_classify u_cls_b (.exp_i(b_q.exp), .man_i(b_q.man),
                           .is_zero_o(b_zero_s), .is_inf_o(b_inf_s), .is_nan_o(b_nan_s));

    assign sign_s     = a_q.sign ^ b_q.sign;
    assign diff_s     = {1'b0, rem_q} - {2'b00, 1'b1, b_q.man};
    assign exp_base_s = $signed({2'b00, a_q.exp}) - $signed({2'b00, b_q.exp})
                      + $signed(10'(FP_EXP_BIAS));

    // Special-operand resolution; NaN outranks Inf which outranks zero
    always_comb begin
        nan_res_s  = a_nan_s | b_nan_s | (a_zero_s & b_zero_s) | (a_inf_s & b_inf_s);
        inf_res_s  = b_zero_s | a_inf_s;
        zero_res_s = a_zero_s | b_inf_s;
        special_s  = nan_res_s | inf_res_s | zero_res_s;
        if (nan_res_s) begin
            special_res_s = FP_NAN;
        end else if (inf_res_s) begin
            special_res_s = FP_INF_MAG | {sign_s, 31'h0};
        end else begin
            special_res_s = 32'h0000_0000;
        end
    end

    // Normalise: quotient MSB decides whether the exponent drops by one
    always_comb begin
        if (quo_q[QW-1]) begin
            man_s = quo_q[QW-2 -: 23];
            exp_s = exp_base_s;
        end else begin
            man_s = quo_q[QW-3 -: 23];
            exp_s = exp_base_s - 10'sd1;
        end
    end

`ifdef ROUND_NEAREST_EN
    logic        guard_s, sticky_s, round_up_s;
    logic [23:0] man_rnd_s;

    // Round-to-nearest-even from guard bit and sticky (leftover bits + remainder)
    always_comb begin
        guard_s    = quo_q[QW-1] ? quo_q[1] : quo_q[0];
        sticky_s   = (quo_q[QW-1] & quo_q[0]) | (rem_q != 25'h0);
        round_up_s = guard_s & (sticky_s | man_s[0]);
        man_rnd_s  = {1'b0, man_s} + {23'h0, round_up_s};
        man_fin_s  = man_rnd_s[22:0];
        if (man_rnd_s[23]) begin
            exp_fin_s = exp_s + 10'sd1;
        end else begin
            exp_fin_s = exp_s;
        end
    end
`else
    assign man_fin_s = man_s;
    assign exp_fin_s = exp_s;
`endif

    // Range limits: overflow saturates to signed Inf, underflow flushes to +0
    always_comb begin
        if (exp_fin_s >= 10'sd255) begin
            norm_res_s = FP_INF_MAG | {sign_s, 31'h0};
        end else if (exp_fin_s <= 10'sd0) begin
            norm_res_s = 32'h0000_0000;
        end else begin
            norm_res_s = fp32_pack(sign_s, exp_fin_s[7:0], man_fin_s);
        end
    end

    // Control FSM and restoring-division datapath next state
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = fp32_t'(bus.dividend);
                    b_d     = fp32_t'(bus.divisor);
                    rem_d   = {2'b01, bus.dividend[22:0]};
                    quo_d   = '0;
                    cnt_d   = 5'd0;
                    state_d = DIVIDE;
                end else begin
                    state_d = IDLE;
                end
            end
            DIVIDE: begin
                if ((cnt_q == 5'd0) && special_s) begin
                    quotient_d  = special_res_s;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    if (!diff_s[25]) begin
                        rem_d = diff_s[24:0] << 1;
                        quo_d = {quo_q[QW-2:0], 1'b1};
                    end else begin
                        rem_d = rem_q << 1;
                        quo_d = {quo_q[QW-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = NORM;
                    end else begin
                        state_d = DIVIDE;
                    end
                end
            end
            NORM: begin
                quotient_d  = norm_res_s;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d     = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
        in_ready_d = (state_d == IDLE);
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= 25'h0;
            quo_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            quotient_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            quotient_q  <= quotient_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.quotient  = quotient_q;

endmodule

// File: tb/tb_divider_float_seq.sv
// Directed, table-driven bench for divider_float_seq with handshake, backpressure and reset sequences.
module tb_divider_float_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

`ifdef ROUND_NEAREST_EN
    localparam int          LAT_N     = 27;
    localparam logic [31:0] ONE_THIRD = 32'h3EAA_AAAB;
    localparam logic [31:0] TWO_THIRD = 32'h3F2A_AAAB;
`else
    localparam int          LAT_N     = 26;
    localparam logic [31:0] ONE_THIRD = 32'h3EAA_AAAA;
    localparam logic [31:0] TWO_THIRD = 32'h3F2A_AAAA;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        int          lat;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    divider_float_seq_if bus_if ();

    divider_float_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Accept one operation and wait (bounded) for its result
    task automatic issue_and_wait(input logic [31:0] a, input logic [31:0] b, output int cyc);
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.dividend = a;
        bus_if.divisor  = b;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        bus_if.dividend = 32'hDEAD_BEEF;
        bus_if.divisor  = 32'h3F80_0000;
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus_if.out_valid) break;
        end
    endtask

    task automatic release_result(input string name);
        @(negedge clk);
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        check32({name, " valid_clr"}, {31'h0, bus_if.out_valid}, 32'h0);
        check32({name, " in_ready_up"}, {31'h0, bus_if.in_ready}, 32'h1);
    endtask

    initial begin
        int          cyc;
        logic [31:0] held;
        string       nm;

        checks = 0;
        errors = 0;
        vecs[0]  = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, LAT_N};
        vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, ONE_THIRD,     LAT_N};
        vecs[2]  = '{32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1};
        vecs[3]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1};
        vecs[4]  = '{32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1};
        vecs[5]  = '{32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 1};
        vecs[6]  = '{32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, LAT_N};
        vecs[7]  = '{32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, LAT_N};
        vecs[8]  = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1};
        vecs[9]  = '{32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, LAT_N};
        vecs[10] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, LAT_N};
        vecs[11] = '{32'h4040_0000, 32'h4000_0000, 32'h3FC0_0000, LAT_N};
        vecs[12] = '{32'h3F80_0000, 32'hC000_0000, 32'hBF00_0000, LAT_N};
        vecs[13] = '{32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 1};
        vecs[14] = '{32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, 1};
        vecs[15] = '{32'h3F80_0000, 32'h3FC0_0000, TWO_THIRD,     LAT_N};

        rst_n            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.dividend  = 32'h0;
        bus_if.divisor   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check32("rst out_valid", {31'h0, bus_if.out_valid}, 32'h0);
        check32("rst quotient", bus_if.quotient, 32'h0);
        check32("rst in_ready", {31'h0, bus_if.in_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            nm = $sformatf("vec%0d", i);
            issue_and_wait(vecs[i].a, vecs[i].b, cyc);
            check_int({nm, " latency"}, cyc, vecs[i].lat);
            check32({nm, " quotient"}, bus_if.quotient, vecs[i].q);
            check32({nm, " in_ready_busy"}, {31'h0, bus_if.in_ready}, 32'h0);
            release_result(nm);
        end

        // Backpressure, with ignored inputs while busy, then back-to-back op
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.dividend = 32'h40C0_0000;
        bus_if.divisor  = 32'h4000_0000;
        @(posedge clk);
        #1;
        bus_if.dividend = 32'h3F80_0000;
        bus_if.divisor  = 32'h4040_0000;
        repeat (3) @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        cyc = 3;
        while (cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus_if.out_valid) break;
        end
        check_int("bp latency", cyc, LAT_N);
        held = bus_if.quotient;
        check32("bp quotient", held, 32'h4040_0000);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check32("bp hold quotient", bus_if.quotient, 32'h4040_0000);
            check32("bp hold valid", {31'h0, bus_if.out_valid}, 32'h1);
            check32("bp hold in_ready", {31'h0, bus_if.in_ready}, 32'h0);
        end
        release_result("bp");
        issue_and_wait(32'h3F80_0000, 32'h3F80_0000, cyc);
        check_int("b2b latency", cyc, LAT_N);
        check32("b2b quotient", bus_if.quotient, 32'h3F80_0000);

        // Asynchronous reset while a division is in flight
        release_result("b2b");
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.dividend = 32'h40C0_0000;
        bus_if.divisor  = 32'h4000_0000;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check32("arst out_valid", {31'h0, bus_if.out_valid}, 32'h0);
        check32("arst quotient", bus_if.quotient, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check32("arst in_ready", {31'h0, bus_if.in_ready}, 32'h1);
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            check32("arst no stale", {31'h0, bus_if.out_valid}, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider_float_seq.md
Name: divider_float_seq

Overview:
Iterative IEEE-754 single-precision divider (quotient = dividend / divisor), the inverse operation to the team's combinational float multiplier, used by the FFT datapath for scaling and normalisation. Restoring division produces one quotient bit per clock. It uses a valid/ready handshake on both input and output sides. Special-value and zero conventions match the multiplier, so the two blocks compose consistently.

Parameters:
NAN_VALUE, 32'h7FC0_0000, canonical quiet NaN returned for every invalid case
EXP_BIAS, 127, exponent bias

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands (high only in IDLE)
dividend  input  32  IEEE-754 single numerator
divisor  input  32  IEEE-754 single denominator
out_valid  output  1  quotient valid, held until accepted
out_ready  input  1  consumer accepts quotient
quotient  output  32  IEEE-754 single result

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE, out_valid=0, quotient=32'h0, iteration counter=0, in_ready=1 once state is IDLE. Reset mid-division aborts the operation; no result is produced.
- Accept: in_valid && in_ready at a rising edge N latches both operands.
- Classification: exp==0 means zero (denormals flushed); exp==255 with mantissa!=0 is NaN; exp==255 with mantissa==0 is Inf.
- Special cases go straight to DONE; out_valid is high after edge N+1:
  - Any NaN, 0/0, or Inf/Inf: NAN_VALUE.
  - Finite nonzero / 0, or Inf / finite: {sign, 8'hFF, 23'h0}.
  - 0 / anything, or finite / Inf: 32'h0000_0000. All zero results are +0.
- Sign of the result = dividend[31] ^ divisor[31].
- States: IDLE -> DIVIDE -> NORM -> DONE -> IDLE.
- DIVIDE runs 25 cycles:
  - Remainder initialised to {1,ma}; divisor D = {1,mb}.
  - Each cycle: trial subtract R-D; if non-negative, q bit=1 and R = (R-D)<<1; otherwise q bit=0 and R = R<<1.
  - q is 25 bits, MSB first, range [2^23, 2^25).
- NORM (1 cycle):
  - If q[24]=1: mantissa = q[23:1], exponent e = ea - eb + EXP_BIAS.
  - Otherwise: mantissa = q[22:0], e = ea - eb + EXP_BIAS - 1.
  - e is evaluated as a 10-bit signed value. e>=255 gives signed Inf. e<=0 gives +0.
  - Default rounding is truncation toward zero.
- DONE: out_valid=1 and quotient is held stable. On out_ready the state returns to IDLE and out_valid is cleared. in_ready rises the cycle after; the same cycle cannot both deliver and accept.
- Normal-case latency: out_valid is high after edge N+26.
- Inputs are ignored while busy. Operand changes after acceptance have no effect.

Optional Feature:
ROUND_NEAREST_EN:
- Defined:
  - DIVIDE runs 26 iterations, producing a guard bit; the final remainder != 0 forms the sticky bit.
  - NORM applies round-to-nearest-even. A mantissa carry-out increments the exponent, and overflow to 255 gives Inf.
  - Normal latency becomes N+27.
- Undefined: truncation, 25 iterations, latency N+26.

Decomposition:
- Package fp32_pkg holds:
  - Constants FP_EXP_BIAS, FP_NAN (7FC00000), FP_INF_MAG (7F800000), FP_EXP_MAX.
  - Enum div_state_t {IDLE, DIVIDE, NORM, DONE}.
  - Struct fp32_t {sign, exp[7:0], man[22:0]}.
- One sub-module, fp32_classify: combinational, produces is_zero/is_inf/is_nan per operand, shareable with the multiplier. Instantiated twice.

Test Plan:
- 6.0/2.0: 40C00000 / 40000000 -> out_valid after N+26, quotient 40400000.
- 1.0/3.0: 3F800000 / 40400000 -> 3EAAAAAA; with ROUND_NEAREST_EN -> 3EAAAAAB at N+27.
- Specials:
  - BF800000 / 00000000 -> FF800000 at N+1.
  - 00000000 / 00000000 -> 7FC00000.
  - 7F800000 / 7F800000 -> 7FC00000.
  - 3F800000 / 7F800000 -> 00000000.
- Range limits:
  - 7F000000 / 00800000 -> 7F800000 (overflow).
  - 00800000 / 7F000000 -> 00000000 (underflow).
- Backpressure: out_ready low for 5 cycles after out_valid -> quotient stable, in_ready=0. Raise out_ready -> in_ready=1 next cycle; back-to-back second operation correct.
- Reset: assert rst_n low at cycle 10 of DIVIDE -> out_valid=0 and quotient=0 immediately (asynchronous), in_ready=1 after release, no stale result emitted.
